gelato_bank_arbiter: RTL and testbench
======================================

# gelato_bank_arbiter

Register-file bank arbiter for the operand-collector stage. It shares `BANK_NUM` single-port register banks between `COLLECTOR_NUM` collector units. Each collector has up to three source-operand reads pending (rs1/rs2/rs3). The block grants at most one read per bank per cycle using per-bank round-robin, and gives each bank's cycle to a writeback when one is present. Read data returns one cycle after the grant, tagged with the collector and operand slot, so collectors can fill `rs_dataN` / `rs_validN`.

## Interface
Parameters:
- `COLLECTOR_NUM`, 4: collector units; requesters R = 3*COLLECTOR_NUM, index i = c*3 + s (s=0..2 → rs1..rs3)
- `BANK_NUM`, 4: register banks, power of two
- `WARP_NUM`, 8: warps; WW = log2(WARP_NUM)
- `REG_NUM`, 32: architectural registers per warp; RW = log2(REG_NUM)
- `THREAD_NUM`, 32: threads per warp
- `DATA_WIDTH`, 32: bits per thread; warp register width WR = THREAD_NUM*DATA_WIDTH
- Derived: BW = log2(BANK_NUM); row width AW = WW + RW - BW

Ports:
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `req_valid` in R: operand read pending, bit i
- `req_warp` in COLLECTOR_NUM*WW: warp of each collector's instruction
- `req_reg` in R*RW: register number per requester
- `req_grant` out R: one-hot per bank, combinational, same cycle as `req_valid`
- `wb_valid` in 1: writeback request
- `wb_warp` in WW: writeback warp
- `wb_rd` in RW: writeback register
- `wb_data` in WR: writeback data
- `wb_mask` in THREAD_NUM: per-thread write enable
- `bank_rd_en` out BANK_NUM: bank read strobe
- `bank_rd_addr` out BANK_NUM*AW: bank row
- `bank_rd_data` in BANK_NUM*WR: bank data, valid one cycle after `bank_rd_en`
- `bank_wr_en` out BANK_NUM: bank write strobe
- `bank_wr_addr` out AW: write row, shared by all banks
- `bank_wr_data` out WR: write data
- `bank_wr_mask` out THREAD_NUM: write mask
- `resp_valid` out BANK_NUM: read data returning from bank b
- `resp_collector` out BANK_NUM*log2(COLLECTOR_NUM): tag
- `resp_rs` out BANK_NUM*2: operand slot, values 0..2
- `resp_data` out BANK_NUM*WR: equals `bank_rd_data` slice b

## Operation
- Bank mapping for (warp w, reg r): bank = (r + w) mod BANK_NUM; row = {w, r[RW-1:BW]}. The mapping is a bijection; warp-skewing spreads identical registers across banks.
- Writeback: `bank_wr_en[bank(wb)]` = `wb_valid`. `bank_wr_addr`, `bank_wr_data`, `bank_wr_mask` are driven combinationally. That bank grants no read this cycle.
- Read arbitration per bank b, among requesters with `req_valid[i]` and bank(i)==b:
  - Round-robin from pointer `rr_ptr[b]` (log2 R bits), searching i = ptr, ptr+1, …, wrapping modulo R.
  - Winner gets `req_grant[i]`=1, and `bank_rd_en[b]`=1 with its row.
  - On a grant, `rr_ptr[b]` ← (winner+1) mod R at the clock edge. With no grant, the pointer holds.
- A requester maps to exactly one bank, so `req_grant` has at most one bit per bank. Different banks grant independently in the same cycle, including rs1/rs2/rs3 of one collector.
- The collector must clear `req_valid[i]` at the edge ending its grant cycle. An ungranted request must stay asserted with stable warp/reg. There is no request merging: identical registers from two requesters serialize.
- Response pipeline per bank: registers `resp_valid[b]`, `resp_collector[b]`, `resp_rs[b]` capture the granted tag at the grant edge. `resp_data[b]` is the combinational pass-through of `bank_rd_data[b]`.

## Timing
- Reset (async, `rst_n`=0): `rr_ptr`=0, `resp_valid`=0, `resp_collector`=0, `resp_rs`=0. Combinational outputs follow inputs, with `req_grant`/`bank_rd_en` still computed.
- Reset mid-operation clears in-flight responses; grants issued in the reset cycle produce no response.
- Latency: grant in cycle T → `resp_valid` in T+1; throughput is 1 read per bank per cycle.
- Read and write to the same row in the same cycle cannot occur: the write wins the bank, and the read retries at T+1 and returns the new data at T+2.
- Pointer wrap: winner R-1 → pointer 0.
- A requester is granted within R cycles unless `wb_valid` targets its bank continuously; writeback has absolute priority, and starvation under sustained writeback is accepted.

## Test plan
- Single read: c0 rs1 (s=0), w0 r1, cycle 0 → `req_grant[0]`=1, `bank_rd_en[1]`=1, row 0; cycle 1 `resp_valid[1]`=1, collector 0, rs 0, data = bank1 row0.
- Bank conflict: c0 s0 w0 r1 and c1 s0 w0 r5 (both bank 1, rows 0/1), pointer 0 → cycle 0 grants i=0, cycle 1 grants i=3; `rr_ptr[1]` becomes 1, then 4.
- Parallel banks: c2 requests w1 r0/r1/r2 (banks 1/2/3) → all three granted in one cycle; three responses next cycle, rs 0/1/2.
- Writeback priority: `wb_valid` w0 r1 mask 0xFFFF_FFFF while c0 reads w0 r1 → `bank_wr_en[1]`=1, no grant; next cycle grant; response returns the written data.
- Round-robin fairness: all 12 requesters on bank 0, re-asserted after each grant → grants in order 0..11, then wrap to 0; no index granted twice within 12 cycles.
- Async reset between grant and response → `resp_valid` 0 immediately, no response appears after release, pointers read 0.

Source files
------------

// File: rtl/gelato_bank_arbiter.sv
// Register-bank arbiter for the operand collector: per-bank round-robin read grants,
// writeback priority per bank, and a one-cycle tagged read-response pipeline.
module gelato_bank_arbiter #(
  parameter int COLLECTOR_NUM = 4,
  parameter int BANK_NUM      = 4,
  parameter int WARP_NUM      = 8,
  parameter int REG_NUM       = 32,
  parameter int THREAD_NUM    = 32,
  parameter int DATA_WIDTH    = 32,
  localparam int R  = 3 * COLLECTOR_NUM,
  localparam int WW = $clog2(WARP_NUM),
  localparam int RW = $clog2(REG_NUM),
  localparam int BW = $clog2(BANK_NUM),
  localparam int AW = WW + RW - BW,
  localparam int WR = THREAD_NUM * DATA_WIDTH,
  localparam int CW = $clog2(COLLECTOR_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [R-1:0]                req_valid,
  input  logic [COLLECTOR_NUM*WW-1:0] req_warp,
  input  logic [R*RW-1:0]             req_reg,
  output logic [R-1:0]                req_grant,
  input  logic                        wb_valid,
  input  logic [WW-1:0]               wb_warp,
  input  logic [RW-1:0]               wb_rd,
  input  logic [WR-1:0]               wb_data,
  input  logic [THREAD_NUM-1:0]       wb_mask,
  output logic [BANK_NUM-1:0]         bank_rd_en,
  output logic [BANK_NUM*AW-1:0]      bank_rd_addr,
  input  logic [BANK_NUM*WR-1:0]      bank_rd_data,
  output logic [BANK_NUM-1:0]         bank_wr_en,
  output logic [AW-1:0]               bank_wr_addr,
  output logic [WR-1:0]               bank_wr_data,
  output logic [THREAD_NUM-1:0]       bank_wr_mask,
  output logic [BANK_NUM-1:0]         resp_valid,
  output logic [BANK_NUM*CW-1:0]      resp_collector,
  output logic [BANK_NUM*2-1:0]       resp_rs,
  output logic [BANK_NUM*WR-1:0]      resp_data
);
  localparam int PW = $clog2(R);

  logic [BW-1:0] req_bank [R];
  logic [AW-1:0] req_row  [R];
  logic [CW-1:0] req_coll [R];
  logic [1:0]    req_slot [R];

  // Warp-skewed mapping: bank = (reg + warp) mod BANK_NUM, row = {warp, reg upper bits}.
  for (genvar gi = 0; gi < R; gi++) begin : g_req
    logic [WW-1:0] warp;
    logic [RW-1:0] rnum;
    assign warp         = req_warp[(gi/3)*WW +: WW];
    assign rnum         = req_reg[gi*RW +: RW];
    assign req_bank[gi] = rnum[BW-1:0] + BW'(warp);
    assign req_row[gi]  = {warp, rnum[RW-1:BW]};
    assign req_coll[gi] = CW'(gi / 3);
    assign req_slot[gi] = 2'(gi % 3);
  end

  logic [BW-1:0] wb_bank;
  assign wb_bank      = wb_rd[BW-1:0] + BW'(wb_warp);
  assign bank_wr_addr = {wb_warp, wb_rd[RW-1:BW]};
  assign bank_wr_data = wb_data;
  assign bank_wr_mask = wb_mask;
  assign resp_data    = bank_rd_data;

  logic [BANK_NUM-1:0] grant_any;
  logic [PW-1:0]       grant_idx [BANK_NUM];

  for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_bank
    logic          wb_hit;
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] rr_ptr_reg;
    logic          resp_valid_reg;
    logic [CW-1:0] resp_coll_reg;
    logic [1:0]    resp_rs_reg;

    assign wb_hit         = wb_valid && (wb_bank == BW'(gi));
    assign bank_wr_en[gi] = wb_hit;

    // Scan from the far end back toward the pointer so the closest match wins.
    always_comb begin
      int            idx;
      logic [PW-1:0] sel;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      sel   = '0;
      if (!wb_hit) begin
        for (int k = R - 1; k >= 0; k--) begin
          idx = int'(rr_ptr_reg) + k;
          if (idx >= R) idx = idx - R;
          sel = PW'(idx);
          if (req_valid[sel] && (req_bank[sel] == BW'(gi))) begin
            found = 1'b1;
            win   = sel;
          end
        end
      end
    end

    assign grant_any[gi]              = found;
    assign grant_idx[gi]              = win;
    assign bank_rd_en[gi]             = found;
    assign bank_rd_addr[gi*AW +: AW]  = found ? req_row[win] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr_reg     <= '0;
        resp_valid_reg <= 1'b0;
        resp_coll_reg  <= '0;
        resp_rs_reg    <= '0;
      end else begin
        resp_valid_reg <= found;
        if (found) begin
          rr_ptr_reg    <= (win == PW'(R - 1)) ? '0 : win + PW'(1);
          resp_coll_reg <= req_coll[win];
          resp_rs_reg   <= req_slot[win];
        end
      end
    end

    assign resp_valid[gi]             = resp_valid_reg;
    assign resp_collector[gi*CW +: CW] = resp_coll_reg;
    assign resp_rs[gi*2 +: 2]         = resp_rs_reg;
  end

  always_comb begin
    req_grant = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (grant_any[b]) req_grant[grant_idx[b]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_gelato_bank_arbiter.sv
// Scoreboard bench for gelato_bank_arbiter: a register-file level model predicts grants
// and read data; a separate monitor matches returning responses against queued expectations.
`timescale 1ns/1ps
module tb_gelato_bank_arbiter;
  localparam int C = 4, B = 4, NW = 8, NR = 32, T = 32, D = 32;
  localparam int R = 3*C, WW = 3, RW = 5, AW = 6, WR = T*D, CW = 2;
  localparam int ROWS = 1 << AW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [R-1:0]        req_valid = '0;
  logic [C*WW-1:0]     req_warp = '0;
  logic [R*RW-1:0]     req_reg = '0;
  logic [R-1:0]        req_grant;
  logic                wb_valid = 1'b0;
  logic [WW-1:0]       wb_warp = '0;
  logic [RW-1:0]       wb_rd = '0;
  logic [WR-1:0]       wb_data = '0;
  logic [T-1:0]        wb_mask = '0;
  logic [B-1:0]        bank_rd_en;
  logic [B*AW-1:0]     bank_rd_addr;
  logic [B*WR-1:0]     bank_rd_data = '0;
  logic [B-1:0]        bank_wr_en;
  logic [AW-1:0]       bank_wr_addr;
  logic [WR-1:0]       bank_wr_data;
  logic [T-1:0]        bank_wr_mask;
  logic [B-1:0]        resp_valid;
  logic [B*CW-1:0]     resp_collector;
  logic [B*2-1:0]      resp_rs;
  logic [B*WR-1:0]     resp_data;

  gelato_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_warp(req_warp), .req_reg(req_reg), .req_grant(req_grant),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_rd(wb_rd), .wb_data(wb_data), .wb_mask(wb_mask),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data),
    .bank_wr_mask(bank_wr_mask),
    .resp_valid(resp_valid), .resp_collector(resp_collector), .resp_rs(resp_rs),
    .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Single-port banks with one-cycle registered read.
  logic [WR-1:0] mem [B][ROWS];
  always @(posedge clk) begin
    for (int b = 0; b < B; b++) begin
      if (bank_rd_en[b]) bank_rd_data[b*WR +: WR] <= mem[b][bank_rd_addr[b*AW +: AW]];
      if (bank_wr_en[b]) begin
        for (int t = 0; t < T; t++)
          if (bank_wr_mask[t]) mem[b][bank_wr_addr][t*D +: D] <= bank_wr_data[t*D +: D];
      end
    end
  end

  // Reference state: architectural register file and per-bank pointers.
  logic [WR-1:0] regfile [NW][NR];
  int            ptr_m [B];
  bit            pv [R];
  int            pwarp [C];
  int            preg [R];
  bit            wbv;
  int            wbw, wbr;
  logic [WR-1:0] wbd;
  logic [T-1:0]  wbm;
  bit            in_reset;
  int            cyc = 0;
  int            vectors = 0, miscompares = 0;
  logic [R-1:0]  last_grant;

  typedef struct { int cyc; int coll; int rs; logic [WR-1:0] data; } exp_t;
  exp_t sbq [B][$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bank_of(int w, int r); return (r + w) % B; endfunction
  function automatic int row_of(int w, int r); return w * (NR / B) + r / B; endfunction

  function automatic logic [WR-1:0] rand_wide();
    logic [WR-1:0] v;
    for (int t = 0; t < T; t++) v[t*D +: D] = $urandom();
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < R; i++) if (pv[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_req(int c, int s, int w, int r);
    pwarp[c] = w;
    pv[c*3 + s] = 1'b1;
    preg[c*3 + s] = r;
  endtask

  task automatic drive();
    for (int i = 0; i < R; i++) begin
      req_valid[i] = pv[i];
      req_reg[i*RW +: RW] = RW'(preg[i]);
    end
    for (int c = 0; c < C; c++) req_warp[c*WW +: WW] = WW'(pwarp[c]);
    wb_valid = wbv;
    wb_warp  = WW'(wbw);
    wb_rd    = RW'(wbr);
    wb_data  = wbd;
    wb_mask  = wbm;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, return after the edge.
  task automatic step();
    logic [R-1:0] eg;
    logic [B-1:0] erd, ewr;
    int           win [B];
    exp_t         e;
    @(negedge clk);
    eg = '0; erd = '0; ewr = '0;
    for (int b = 0; b < B; b++) begin
      win[b] = -1;
      if (wbv && bank_of(wbw, wbr) == b) ewr[b] = 1'b1;
      else begin
        for (int k = 0; k < R; k++) begin
          int i;
          i = (ptr_m[b] + k) % R;
          if (win[b] < 0 && pv[i] && bank_of(pwarp[i/3], preg[i]) == b) win[b] = i;
        end
      end
      if (win[b] >= 0) begin
        eg[win[b]] = 1'b1;
        erd[b] = 1'b1;
      end
    end
    last_grant = req_grant;
    chk("req_grant", 64'(req_grant), 64'(eg));
    chk("bank_rd_en", 64'(bank_rd_en), 64'(erd));
    chk("bank_wr_en", 64'(bank_wr_en), 64'(ewr));
    for (int b = 0; b < B; b++)
      if (win[b] >= 0)
        chk("bank_rd_addr", 64'(bank_rd_addr[b*AW +: AW]),
            64'(row_of(pwarp[win[b]/3], preg[win[b]])));
    if (wbv) begin
      chk("bank_wr_addr", 64'(bank_wr_addr), 64'(row_of(wbw, wbr)));
      chk("bank_wr_mask", 64'(bank_wr_mask), 64'(wbm));
    end
    if (!in_reset) begin
      for (int b = 0; b < B; b++) begin
        if (win[b] >= 0) begin
          e.cyc  = cyc;
          e.coll = win[b] / 3;
          e.rs   = win[b] % 3;
          e.data = regfile[pwarp[win[b]/3]][preg[win[b]]];
          sbq[b].push_back(e);
          ptr_m[b] = (win[b] + 1) % R;
          pv[win[b]] = 1'b0;
        end
      end
    end
    if (wbv)
      for (int t = 0; t < T; t++)
        if (wbm[t]) regfile[wbw][wbr][t*D +: D] = wbd[t*D +: D];
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    wbv = 1'b0;
    while (any_pending() && n < 100) begin
      drive();
      step();
      n++;
    end
    if (any_pending()) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got requests still pending expected all granted within 100 cycles");
      for (int i = 0; i < R; i++) pv[i] = 1'b0;
    end
    drive();
    step();
    step();
  endtask

  task automatic gen();
    for (int c = 0; c < C; c++) begin
      if (!pv[c*3] && !pv[c*3+1] && !pv[c*3+2] && $urandom_range(1, 0) == 1) begin
        pwarp[c] = $urandom_range(NW - 1, 0);
        for (int s = 0; s < 3; s++)
          if ($urandom_range(2, 0) != 0) begin
            pv[c*3 + s] = 1'b1;
            preg[c*3 + s] = $urandom_range(NR - 1, 0);
          end
      end
    end
    wbv = ($urandom_range(3, 0) == 0);
    if (wbv) begin
      wbw = $urandom_range(NW - 1, 0);
      wbr = $urandom_range(NR - 1, 0);
      wbm = ($urandom_range(1, 0) == 1) ? '1 : T'($urandom());
      wbd = rand_wide();
    end
  endtask

  // Monitor: every returning response must match the oldest expectation for its bank.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int b = 0; b < B; b++) begin
        if (resp_valid[b]) begin
          if (sbq[b].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL resp_unexpected bank %0d: got resp_valid 1 expected 0", b);
          end else begin
            e = sbq[b].pop_front();
            chk("resp_collector", 64'(resp_collector[b*CW +: CW]), 64'(e.coll));
            chk("resp_rs", 64'(resp_rs[b*2 +: 2]), 64'(e.rs));
            vectors++;
            if (resp_data[b*WR +: WR] !== e.data) begin
              miscompares++;
              $display("FAIL resp_data bank %0d: got %h expected %h (low 64 bits)",
                       b, resp_data[b*WR +: 64], e.data[63:0]);
            end
          end
        end else if (sbq[b].size() > 0 && sbq[b][0].cyc < cyc) begin
          e = sbq[b].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL resp_missing bank %0d: got resp_valid 0 expected 1 (grant cycle %0d)", b, e.cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < R; i++) begin pv[i] = 1'b0; preg[i] = 0; end
    for (int c = 0; c < C; c++) pwarp[c] = 0;
    for (int b = 0; b < B; b++) ptr_m[b] = 0;
    wbv = 1'b0; wbw = 0; wbr = 0; wbd = '0; wbm = '0;
    in_reset = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp_valid", 64'(resp_valid), 64'(0));
    chk("reset_resp_collector", 64'(resp_collector), 64'(0));
    chk("reset_resp_rs", 64'(resp_rs), 64'(0));
    rst_n = 1'b1;
    in_reset = 1'b0;

    // Fill every architectural register through the writeback path.
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NR; r++) begin
        wbv = 1'b1; wbw = w; wbr = r; wbm = '1; wbd = rand_wide();
        drive();
        step();
      end
    wbv = 1'b0;
    drive();
    step();

    // Bank conflict on bank 1 with pointer 0: i=0 then i=3.
    set_req(0, 0, 0, 1);
    set_req(1, 0, 0, 5);
    drive(); step();
    chk("conflict_first", 64'(last_grant), 64'(12'h001));
    drive(); step();
    chk("conflict_second", 64'(last_grant), 64'(12'h008));
    drain();

    // Single read.
    set_req(0, 0, 0, 1);
    drive(); step();
    chk("single_grant", 64'(last_grant), 64'(12'h001));
    drain();

    // Parallel banks: one collector's three operands in one cycle.
    set_req(2, 0, 1, 0);
    set_req(2, 1, 1, 1);
    set_req(2, 2, 1, 2);
    drive(); step();
    chk("parallel_grant", 64'(last_grant), 64'(12'h1C0));
    drain();

    // Writeback takes the bank; the read retries next cycle and sees the new data.
    set_req(0, 0, 0, 1);
    wbv = 1'b1; wbw = 0; wbr = 1; wbm = '1; wbd = rand_wide();
    drive(); step();
    chk("wb_blocks_grant", 64'(last_grant), 64'(0));
    wbv = 1'b0;
    drive(); step();
    chk("wb_retry_grant", 64'(last_grant), 64'(12'h001));
    drain();

    // Round-robin fairness: all requesters on bank 0, re-asserted every cycle.
    for (int c = 0; c < C; c++) pwarp[c] = 0;
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < R; i++) begin pv[i] = 1'b1; preg[i] = 4 * (i % 3); end
      drive(); step();
      chk("rr_order", 64'(last_grant), 64'(1) << (k % 12));
    end
    for (int i = 0; i < R; i++) pv[i] = 1'b0;
    drain();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      gen(); drive(); step();
    end
    drain();

    // Async reset between grant and response; bank 1 pointer is non-zero beforehand.
    set_req(0, 0, 0, 1);
    drive(); step();
    chk("pre_reset_resp_valid", 64'(resp_valid[1]), 64'(1));
    rst_n = 1'b0;
    in_reset = 1'b1;
    for (int b = 0; b < B; b++) begin sbq[b].delete(); ptr_m[b] = 0; end
    #1;
    chk("reset_resp_valid_async", 64'(resp_valid), 64'(0));
    set_req(0, 0, 0, 1);
    set_req(1, 0, 0, 5);
    drive(); step();
    chk("reset_cycle_grant", 64'(last_grant), 64'(12'h001));
    rst_n = 1'b1;
    in_reset = 1'b0;
    drive(); step();
    chk("post_reset_grant", 64'(last_grant), 64'(12'h001));
    drain();

    for (int n = 0; n < 200; n++) begin
      gen(); drive(); step();
    end
    drain();

    for (int b = 0; b < B; b++) chk("scoreboard_empty", 64'(sbq[b].size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
